// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg
// Shared definitions for the EX->MEM pipeline register.
//   - Default widths of the stage (datapath, register address, mem-op, stall counter)
//   - Mem-op encodings (loads have bit 3 set, stores live at 4..6)
//   - ex_mem_pl_t : payload layout {rd, we, res, mop, sdata} at the default widths
//   - is_load()   : true for any load mem-op
package ex_mem_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int RA_W_DEF     = 5;
    localparam int MOP_W_DEF    = 4;
    localparam int STALLC_W_DEF = 16;

    localparam logic [MOP_W_DEF-1:0] MOP_NONE = 4'h0;
    localparam logic [MOP_W_DEF-1:0] MOP_SB   = 4'h4;
    localparam logic [MOP_W_DEF-1:0] MOP_SH   = 4'h5;
    localparam logic [MOP_W_DEF-1:0] MOP_SW   = 4'h6;
    localparam logic [MOP_W_DEF-1:0] MOP_LB   = 4'h8;
    localparam logic [MOP_W_DEF-1:0] MOP_LH   = 4'h9;
    localparam logic [MOP_W_DEF-1:0] MOP_LW   = 4'hA;
    localparam logic [MOP_W_DEF-1:0] MOP_LBU  = 4'hB;
    localparam logic [MOP_W_DEF-1:0] MOP_LHU  = 4'hC;

    typedef struct packed {
        logic [RA_W_DEF-1:0]  rd;
        logic                 we;
        logic [XLEN_DEF-1:0]  res;
        logic [MOP_W_DEF-1:0] mop;
        logic [XLEN_DEF-1:0]  sdata;
    } ex_mem_pl_t;

    // All load encodings share bit 3; stores and MOP_NONE keep it clear.
    function automatic logic is_load(input logic [MOP_W_DEF-1:0] mop);
        return mop[3];
    endfunction

endpackage

// File: rtl/ex_mem_pipe_stage_slot.sv
// ex_mem_slot
// One payload register plus its valid bit.
//   clk, rst : clock and synchronous active-high reset (clears valid and payload)
//   flush    : drop the held entry (payload left as is, it is don't-care)
//   load     : capture d and mark valid (wins over clear)
//   clear    : mark invalid (entry consumed downstream)
//   d        : incoming payload, W bits
//   valid, q : registered valid bit and payload
module ex_mem_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Priority: reset, then flush, then a new load, then consumption.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// ex_mem_pipe_stage
// EX->MEM pipeline register with valid/ready on both sides.
//   ex_*  : instruction from the ALU stage (valid/ready, rd, we, result, mem-op, store data)
//   mm_*  : registered instruction towards the memory stage (valid/ready + payload)
//   fwd_en_o    : held result may be bypassed (valid, writes a register, not a load)
//   load_use_o  : held instruction is a load; decode must stall dependants
//   stall_cnt_o : saturating count of cycles the memory stage refused a valid instruction
//   flush_i     : branch redirect, kills held and incoming instructions
// Build option: define EX_MEM_SKID_EN to add a second (skid) slot so that
// ex_ready_o becomes a plain register output with no path from mm_ready_i.
module ex_mem_pipe_stage
    import ex_mem_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int RA_W     = RA_W_DEF,
    parameter int MOP_W    = MOP_W_DEF,
    parameter int STALLC_W = STALLC_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                ex_valid_i,
    output logic                ex_ready_o,
    input  logic [RA_W-1:0]     ex_rd_i,
    input  logic                ex_we_i,
    input  logic [XLEN-1:0]     ex_res_i,
    input  logic [MOP_W-1:0]    ex_mop_i,
    input  logic [XLEN-1:0]     ex_sdata_i,
    output logic                mm_valid_o,
    input  logic                mm_ready_i,
    output logic [RA_W-1:0]     mm_rd_o,
    output logic                mm_we_o,
    output logic [XLEN-1:0]     mm_res_o,
    output logic [MOP_W-1:0]    mm_mop_o,
    output logic [XLEN-1:0]     mm_sdata_o,
    output logic                fwd_en_o,
    output logic                load_use_o,
    output logic [STALLC_W-1:0] stall_cnt_o
);

    // Same layout as ex_mem_pl_t, but sized from this instance's parameters.
    typedef struct packed {
        logic [RA_W-1:0]  rd;
        logic             we;
        logic [XLEN-1:0]  res;
        logic [MOP_W-1:0] mop;
        logic [XLEN-1:0]  sdata;
    } pl_t;

    pl_t  in_pl;
    pl_t  main_pl;
    logic main_valid;
    logic accept;
    logic emit;

    // Writes to x0 are killed here so nothing downstream has to check rd.
    assign in_pl.rd    = ex_rd_i;
    assign in_pl.we    = ex_we_i & (ex_rd_i != '0);
    assign in_pl.res   = ex_res_i;
    assign in_pl.mop   = ex_mop_i;
    assign in_pl.sdata = ex_sdata_i;

    assign accept = ex_valid_i & ex_ready_o;
    assign emit   = main_valid & mm_ready_i;

`ifdef EX_MEM_SKID_EN
    pl_t  skid_pl;
    pl_t  main_d;
    logic skid_valid;
    logic main_load;
    logic skid_load;
    logic skid_clear;

    // Ready only depends on skid occupancy, breaking the mm_ready_i -> ex_ready_o path.
    assign ex_ready_o = !skid_valid;

    // Main refills whenever it is free or draining; the skid entry is older, so it goes first.
    assign main_load  = (!main_valid | mm_ready_i) & (skid_valid | accept);
    assign main_d     = skid_valid ? skid_pl : in_pl;

    // An accept that main cannot take this cycle parks in the skid slot.
    assign skid_load  = accept & main_valid & !mm_ready_i;
    assign skid_clear = skid_valid & main_load;

    ex_mem_slot #(.W($bits(pl_t))) u_main_slot (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_i),
        .load  (main_load),
        .clear (emit),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_pl)
    );

    ex_mem_slot #(.W($bits(pl_t))) u_skid_slot (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_i),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_pl),
        .valid (skid_valid),
        .q     (skid_pl)
    );
`else
    // Accepting while draining lets a new instruction replace the old one without a bubble.
    assign ex_ready_o = !main_valid | mm_ready_i;

    ex_mem_slot #(.W($bits(pl_t))) u_main_slot (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_i),
        .load  (accept),
        .clear (emit),
        .d     (in_pl),
        .valid (main_valid),
        .q     (main_pl)
    );
`endif

    assign mm_valid_o = main_valid;
    assign mm_rd_o    = main_pl.rd;
    assign mm_we_o    = main_pl.we;
    assign mm_res_o   = main_pl.res;
    assign mm_mop_o   = main_pl.mop;
    assign mm_sdata_o = main_pl.sdata;

    // A load's result is an address, not the loaded data, so it must never be forwarded.
    assign fwd_en_o   = main_valid & main_pl.we & !is_load(main_pl.mop);
    assign load_use_o = main_valid & is_load(main_pl.mop);

    // Counts only real back-pressure; bubbles do not count. Saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (main_valid && !mm_ready_i && !(&stall_cnt_o)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule
